// File: rtl/vend_sequencer.sv
// vend_sequencer: vending controller FSM (collect, calc, dispense, payout).
// Define VEND_AUDIT_EN to add the sales_count/revenue audit counters.
module vend_sequencer #(
  parameter int N          = 7,
  parameter int PRICE0     = 35,
  parameter int PRICE1     = 50,
  parameter int PRICE2     = 65,
  parameter int PRICE3     = 90,
  parameter int MAX_CREDIT = 100,
  parameter int TIMEOUT    = 255
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         coin_valid,
  input  logic [1:0]   coin_type,
  input  logic         item_valid,
  input  logic [1:0]   item_sel,
  input  logic         cancel,
  input  logic [N-1:0] change_in,
  input  logic         coin_out_ready,
  output logic [15:0]  accumulator,
  output logic [15:0]  item_val,
  output logic         change_calculator_en,
  output logic         coin_reject,
  output logic         price_low,
  output logic         dispense,
  output logic         coin_out_valid,
  output logic [1:0]   coin_out_type,
  output logic         done
`ifdef VEND_AUDIT_EN
  ,
  output logic [15:0]  sales_count,
  output logic [15:0]  revenue
`endif
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, COLLECT, CALC, DISPENSE, PAYOUT} state_t;
  state_t         state_q;
  logic [15:0]    acc_q, item_q, coin_amt, price;
  logic [N-1:0]   rem_q, pay;
  logic [TW-1:0]  timer_q;
  logic [1:0]     cot_q;
  logic [16:0]    sum;
  logic           en_q, rej_q, low_q, disp_q, cov_q, done_q, refund, over;
  function automatic logic [N-1:0] amt_of(input logic [1:0] t);
    return t == 2'd0 ? N'(5) : t == 2'd1 ? N'(10) : t == 2'd2 ? N'(25) : N'(50);
  endfunction
  function automatic logic [1:0] pick(input logic [N-1:0] r);
    return r >= N'(50) ? 2'd3 : r >= N'(25) ? 2'd2 : r >= N'(10) ? 2'd1 : 2'd0;
  endfunction
  always_comb begin
    coin_amt = 16'(amt_of(coin_type));
    price    = item_sel == 2'd0 ? 16'(PRICE0) : item_sel == 2'd1 ? 16'(PRICE1) :
               item_sel == 2'd2 ? 16'(PRICE2) : 16'(PRICE3);
    sum      = 17'(acc_q) + 17'(coin_amt);
    over     = sum > 17'(MAX_CREDIT);
    refund   = cancel || timer_q == TW'(TIMEOUT);
    // Next remaining change: fresh result, held value, or after the current coin is taken
    pay      = state_q == CALC ? change_in : state_q == DISPENSE ? rem_q : rem_q - amt_of(cot_q);
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      acc_q   <= '0;
      item_q  <= '0;
      rem_q   <= '0;
      timer_q <= '0;
      cot_q   <= '0;
      en_q    <= 1'b0;
      rej_q   <= 1'b0;
      low_q   <= 1'b0;
      disp_q  <= 1'b0;
      cov_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      en_q   <= 1'b0;
      low_q  <= 1'b0;
      disp_q <= 1'b0;
      rej_q  <= coin_valid && state_q != IDLE &&
                (state_q != COLLECT || refund || item_valid || over);
      case (state_q)
        IDLE: if (coin_valid) begin
          acc_q   <= sum[15:0];
          timer_q <= '0;
          state_q <= COLLECT;
        end
        COLLECT: begin
          timer_q <= timer_q + 1'b1;
          if (refund) begin
            item_q  <= '0;
            en_q    <= 1'b1;
            state_q <= CALC;
          end else if (item_valid && acc_q >= price) begin
            item_q  <= price;
            en_q    <= 1'b1;
            state_q <= CALC;
          end else if (item_valid) begin
            low_q   <= 1'b1;
            timer_q <= '0;
          end else if (coin_valid) begin
            timer_q <= '0;
            if (!over) acc_q <= sum[15:0];
          end
        end
        CALC: begin
          rem_q <= pay;
          if (item_q != '0) begin
            disp_q  <= 1'b1;
            state_q <= DISPENSE;
          end else begin
            done_q  <= pay == '0;
            cov_q   <= pay != '0;
            cot_q   <= pick(pay);
            state_q <= PAYOUT;
          end
        end
        DISPENSE: begin
          done_q  <= pay == '0;
          cov_q   <= pay != '0;
          cot_q   <= pick(pay);
          state_q <= PAYOUT;
        end
        PAYOUT: if (done_q) begin
          done_q  <= 1'b0;
          acc_q   <= '0;
          item_q  <= '0;
          state_q <= IDLE;
        end else if (coin_out_ready) begin
          rem_q  <= pay;
          done_q <= pay == '0;
          cov_q  <= pay != '0;
          cot_q  <= pick(pay);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign accumulator          = acc_q;
  assign item_val             = item_q;
  assign change_calculator_en = en_q;
  assign coin_reject          = rej_q;
  assign price_low            = low_q;
  assign dispense             = disp_q;
  assign coin_out_valid       = cov_q;
  assign coin_out_type        = cot_q;
  assign done                 = done_q;
`ifdef VEND_AUDIT_EN
  logic [15:0] sales_q, rev_q;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sales_q <= '0;
      rev_q   <= '0;
    end else if (disp_q) begin
      sales_q <= sales_q + 16'd1;
      rev_q   <= rev_q + item_q;
    end
  end
  assign sales_count = sales_q;
  assign revenue     = rev_q;
`endif
endmodule
